// File: rtl/glitc_refclk_freq_meter.sv
// Reference-clock edge-rate meter.
// Counts rising edges on each monitored REFCLK copy over a fixed gate window
// of clk_i cycles. Each window's count is held, and one channel's held count
// is presented for readback.

// Per-channel edge counter: synchronizer, edge detect, saturating accumulator
// and held result.
module glitc_refclk_chan #(
    parameter int COUNT_WIDTH = 10
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   refclk_i,
    input  logic                   clr_i,
    input  logic                   term_i,
    output logic [COUNT_WIDTH-1:0] result_o
);

    logic [1:0]             sync;
    logic                   hist;
    logic                   edge_det;
    logic [COUNT_WIDTH-1:0] acc;
    logic [COUNT_WIDTH-1:0] acc_inc;

    // Two-flop synchronizer for the async refclk, plus one history flop for edge detect
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync <= '0;
            hist <= 1'b0;
        end else begin
            sync <= {sync[0], refclk_i};
            hist <= sync[1];
        end
    end

    assign edge_det = sync[1] & ~hist;

    // Saturate instead of wrapping, so an over-range input reads full scale
    assign acc_inc = (edge_det && (acc != '1)) ? acc + 1'b1 : acc;

    // Accumulate edges across the window.
    // On the terminal cycle, hand the total (including this cycle's edge) to result.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc      <= '0;
            result_o <= '0;
        end else if (clr_i) begin
            acc      <= '0;
            result_o <= '0;
        end else if (term_i) begin
            acc      <= '0;
            result_o <= acc_inc;
        end else begin
            acc      <= acc_inc;
        end
    end

endmodule

module glitc_refclk_freq_meter #(
    parameter int NUM_CLK     = 6,
    parameter int COUNT_WIDTH = 10,
    parameter int GATE_CYCLES = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_CLK-1:0]     refclk_i,
    input  logic [3:0]             refclk_select_i,
    input  logic                   refclk_select_wr_i,
    output logic [COUNT_WIDTH-1:0] refclk_count_o,
    output logic                   count_valid_o
);

    localparam int               GW        = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);

    logic [GW-1:0]                          gate_cnt;
    logic                                   term;
    logic [3:0]                             sel;
    logic [NUM_CLK-1:0][COUNT_WIDTH-1:0]    result;
    logic [COUNT_WIDTH-1:0]                 sel_data;

    assign term = (gate_cnt == GATE_LAST);

    // Gate window counter.
    // A select write restarts the window so that the first result covers a full window.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                   gate_cnt <= '0;
        else if (refclk_select_wr_i) gate_cnt <= '0;
        else if (term)               gate_cnt <= '0;
        else                         gate_cnt <= gate_cnt + 1'b1;
    end

    // One counter per monitored line
    for (genvar n = 0; n < NUM_CLK; n++) begin : g_chan
        glitc_refclk_chan #(
            .COUNT_WIDTH (COUNT_WIDTH)
        ) u_chan (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .refclk_i (refclk_i[n]),
            .clr_i    (refclk_select_wr_i),
            .term_i   (term),
            .result_o (result[n])
        );
    end

    // Readback mux; selects beyond the populated channels read 0
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_CLK; i++)
            if (sel == 4'(i)) sel_data = result[i];
    end

    // Select register, valid flag and registered readout.
    // A write wins over a coincident terminal cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sel            <= '0;
            count_valid_o  <= 1'b0;
            refclk_count_o <= '0;
        end else begin
            refclk_count_o <= sel_data;
            if (refclk_select_wr_i) begin
                sel           <= refclk_select_i;
                count_valid_o <= 1'b0;
            end else if (term) begin
                count_valid_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_glitc_refclk_freq_meter.sv
// Directed bench for glitc_refclk_freq_meter.
// Instance A uses the default 1024-cycle gate.
// Instance B uses a 4096-cycle gate to drive the counter into saturation.
// Reference lines toggle at fixed periods, phased away from clk edges.
module tb_glitc_refclk_freq_meter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sel = 4'd0;
    logic       wr  = 1'b0;
    logic       en0 = 1'b0;
    logic       r0 = 1'b0, r1 = 1'b0, r2 = 1'b0, r3 = 1'b0, r4 = 1'b0, r5 = 1'b0;
    logic [5:0] refclk;
    logic [9:0] cnt_a, cnt_b;
    logic       vld_a, vld_b;

    int checks = 0;
    int errors = 0;

    assign refclk = {r5, r4, r3, r2, r1, r0};

    // clk period 10 ns (posedges at 5 + 10k); all refclk toggles land at 2 + 10k
    always #5 clk = ~clk;
    initial begin #2; forever #10  r1 = ~r1; end   // period 2 clk
    initial begin #2; forever #40  r2 = ~r2; end   // period 8 clk
    initial begin #2; forever #80  r3 = ~r3; end   // period 16 clk
    initial begin #2; forever #160 r4 = ~r4; end   // period 32 clk
    initial begin #2; forever #20  r5 = ~r5; end   // period 4 clk
    initial begin #2; forever begin #30; r0 = en0 ? ~r0 : 1'b0; end end

    glitc_refclk_freq_meter u_dut_a (
        .clk_i              (clk),
        .rst_i              (rst),
        .refclk_i           (refclk),
        .refclk_select_i    (sel),
        .refclk_select_wr_i (wr),
        .refclk_count_o     (cnt_a),
        .count_valid_o      (vld_a)
    );

    glitc_refclk_freq_meter #(.GATE_CYCLES(4096)) u_dut_b (
        .clk_i              (clk),
        .rst_i              (rst),
        .refclk_i           (refclk),
        .refclk_select_i    (sel),
        .refclk_select_wr_i (wr),
        .refclk_count_o     (cnt_b),
        .count_valid_o      (vld_b)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr_sel(input logic [3:0] v);
        sel = v;
        wr  = 1'b1;
        tick(1);
        wr  = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_cnt_a", 32'(cnt_a), 32'd0);
        chk("rst_vld_a", 32'(vld_a), 32'd0);
        chk("rst_cnt_b", 32'(cnt_b), 32'd0);
        chk("rst_vld_b", 32'(vld_b), 32'd0);
        tick(3);
        rst = 1'b0;

        // Channel 2, period 8 -> 128 per 1024-cycle window
        wr_sel(4'd2);
        tick(1023);
        chk("p8_vld_pre", 32'(vld_a), 32'd0);
        tick(1);
        chk("p8_vld", 32'(vld_a), 32'd1);
        chk("p8_cnt_lag", 32'(cnt_a), 32'd0);
        tick(1);
        chk("p8_cnt", 32'(cnt_a), 32'd128);
        tick(500);
        chk("p8_stable", 32'(cnt_a), 32'd128);

        // Channel 5, period 4 -> 256
        wr_sel(4'd5);
        tick(1);
        chk("p4_clr_cnt", 32'(cnt_a), 32'd0);
        chk("p4_clr_vld", 32'(vld_a), 32'd0);
        tick(1022);
        chk("p4_vld_pre", 32'(vld_a), 32'd0);
        tick(1);
        chk("p4_vld", 32'(vld_a), 32'd1);
        tick(1);
        chk("p4_cnt", 32'(cnt_a), 32'd256);

        // Reset mid-window clears everything at once; sel returns to 0 (line held low)
        tick(300);
        rst = 1'b1;
        #1;
        chk("mid_rst_cnt", 32'(cnt_a), 32'd0);
        chk("mid_rst_vld", 32'(vld_a), 32'd0);
        tick(2);
        rst = 1'b0;
        tick(1023);
        chk("post_rst_vld_pre", 32'(vld_a), 32'd0);
        tick(1);
        chk("post_rst_vld", 32'(vld_a), 32'd1);
        tick(1);
        chk("post_rst_sel0_cnt", 32'(cnt_a), 32'd0);

        // Out-of-range selects read 0 with every line toggling
        en0 = 1'b1;
        wr_sel(4'd7);
        tick(1);
        chk("sel7_cnt0", 32'(cnt_a), 32'd0);
        tick(1023);
        chk("sel7_vld", 32'(vld_a), 32'd1);
        tick(1);
        chk("sel7_cnt", 32'(cnt_a), 32'd0);
        wr_sel(4'd15);
        tick(1024);
        chk("sel15_vld", 32'(vld_a), 32'd1);
        tick(1);
        chk("sel15_cnt", 32'(cnt_a), 32'd0);
        en0 = 1'b0;

        // Channel 3, period 16 -> 64; then a write landing on the terminal cycle
        wr_sel(4'd3);
        tick(1024);
        chk("p16_vld", 32'(vld_a), 32'd1);
        tick(1);
        chk("p16_cnt", 32'(cnt_a), 32'd64);
        tick(1022);             // gate counter now at its last count
        wr_sel(4'd3);           // strobe sampled on the terminal edge
        chk("term_wr_vld", 32'(vld_a), 32'd0);
        tick(1);
        chk("term_wr_cnt", 32'(cnt_a), 32'd0);
        tick(1022);
        chk("term_wr_vld_pre", 32'(vld_a), 32'd0);
        tick(1);
        chk("term_wr_vld_next", 32'(vld_a), 32'd1);
        tick(1);
        chk("term_wr_cnt_next", 32'(cnt_a), 32'd64);

        // Channel 1, period 2: 512 in a 1024 window, saturates in a 4096 window
        wr_sel(4'd1);
        tick(1024);
        chk("p2_vld_a", 32'(vld_a), 32'd1);
        chk("p2_vld_b_pre", 32'(vld_b), 32'd0);
        tick(1);
        chk("p2_cnt_a", 32'(cnt_a), 32'd512);
        tick(3071);
        chk("sat_vld_b", 32'(vld_b), 32'd1);
        tick(1);
        chk("sat_cnt_b", 32'(cnt_b), 32'd1023);
        tick(4096);
        chk("sat_nowrap_b", 32'(cnt_b), 32'd1023);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
